// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder.
// Raw ps2_clk/ps2_data are synchronized, and the clock is glitch-filtered.
// Each frame (start, 8 data LSB first, odd parity, stop) is shifted in on the filtered falling edges.
// Valid bytes are decoded for the E0 (extended) and F0 (break) prefixes.
// The last make code is presented on keycode, with a one-cycle strobe per make.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit CLEAR_ON_BREAK = 1'b1
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       newkeyStrobe,
    output logic       extended,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // The frame is good when the 8 data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic [FW-1:0] filt_cnt_r;
    logic          filt_level_r;
    logic          fall_tick_r;

    rx_state_t     state_r, state_s;
    logic [2:0]    bitcnt_r;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [TW-1:0] tout_r;
    logic          byte_valid_r;
    logic          frame_err_r;
    logic          shift_en_s, cap_par_s, good_s, err_s, tout_hit_s;

    logic [7:0]    keycode_r;
    logic          extended_r, strobe_r, ext_pend_r, break_pend_r;

    // Two-flop synchronizers for the asynchronous PS/2 lines; the lines idle high.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Glitch filter: the level flips after FILTER_LEN consecutive differing samples; 1->0 gives fall_tick.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            filt_cnt_r   <= '0;
            filt_level_r <= 1'b1;
            fall_tick_r  <= 1'b0;
        end else if (clk_sync_r == filt_level_r) begin
            filt_cnt_r  <= '0;
            fall_tick_r <= 1'b0;
        end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
            filt_level_r <= clk_sync_r;
            filt_cnt_r   <= '0;
            fall_tick_r  <= filt_level_r;
        end else begin
            filt_cnt_r  <= filt_cnt_r + FW'(1'b1);
            fall_tick_r <= 1'b0;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Receive FSM next state and per-cycle control strobes.
    always_comb begin
        state_s    = state_r;
        shift_en_s = 1'b0;
        cap_par_s  = 1'b0;
        good_s     = 1'b0;
        err_s      = 1'b0;
        tout_hit_s = (tout_r == TW'(TIMEOUT_CYCLES - 1));
        case (state_r)
            IDLE: begin
                if (fall_tick_r) begin
                    if (!data_sync_r) begin
                        state_s = DATA;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (fall_tick_r) begin
                    shift_en_s = 1'b1;
                    if (bitcnt_r == 3'd7) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                    end
                end else if (tout_hit_s) begin
                    state_s = IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (fall_tick_r) begin
                    cap_par_s = 1'b1;
                    state_s   = STOP;
                end else if (tout_hit_s) begin
                    state_s = IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (fall_tick_r) begin
                    state_s = IDLE;
                    if (data_sync_r && odd_parity_ok(shift_r, par_r)) begin
                        good_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (tout_hit_s) begin
                    state_s = IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Receive datapath: bit counter, shift register, parity capture, timeout counter, result pulses.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            bitcnt_r     <= 3'd0;
            shift_r      <= 8'h00;
            par_r        <= 1'b0;
            tout_r       <= '0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                bitcnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bitcnt_r <= bitcnt_r + 3'd1;
            end
            if (shift_en_s) begin
                shift_r <= {data_sync_r, shift_r[7:1]};
            end
            if (cap_par_s) begin
                par_r <= data_sync_r;
            end
            if ((state_r == IDLE) || fall_tick_r) begin
                tout_r <= '0;
            end else begin
                tout_r <= tout_r + TW'(1'b1);
            end
            byte_valid_r <= good_s;
            frame_err_r  <= err_s;
        end
    end

    // Scan-code decode: track E0/F0 prefixes, load make codes with a strobe, clear on a matching break.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            keycode_r    <= 8'h00;
            extended_r   <= 1'b0;
            strobe_r     <= 1'b0;
            ext_pend_r   <= 1'b0;
            break_pend_r <= 1'b0;
        end else begin
            strobe_r <= 1'b0;
            if (byte_valid_r) begin
                if (shift_r == 8'hE0) begin
                    ext_pend_r <= 1'b1;
                end else if (shift_r == 8'hF0) begin
                    break_pend_r <= 1'b1;
                end else if (break_pend_r) begin
                    break_pend_r <= 1'b0;
                    ext_pend_r   <= 1'b0;
                    if (CLEAR_ON_BREAK && (shift_r == keycode_r) && (ext_pend_r == extended_r)) begin
                        keycode_r  <= 8'h00;
                        extended_r <= 1'b0;
                    end
                end else begin
                    keycode_r  <= shift_r;
                    extended_r <= ext_pend_r;
                    ext_pend_r <= 1'b0;
                    strobe_r   <= 1'b1;
                end
            end
        end
    end

    assign keycode      = keycode_r;
    assign extended     = extended_r;
    assign newkeyStrobe = strobe_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized self-checking bench for ps2_key_decoder.
// Two instances share the PS/2 lines: one clears on a break, one does not.
// A frame-level model predicts every strobe/error pulse and the held keycode level.
module tb_ps2_key_decoder;

    localparam int FL      = 8;
    localparam int TO      = 2000;
    localparam int HALF    = 16;
    localparam int LATENCY = 2 + FL + 2;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kc_a, kc_b;
    logic       stb_a, stb_b, ext_a, ext_b, err_a, err_b;

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .CLEAR_ON_BREAK(1'b1)) dut_a (
        .CLK(CLK), .RESETN(RESETN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(kc_a), .newkeyStrobe(stb_a), .extended(ext_a), .frame_err(err_a));

    ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .CLEAR_ON_BREAK(1'b0)) dut_b (
        .CLK(CLK), .RESETN(RESETN), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(kc_b), .newkeyStrobe(stb_b), .extended(ext_b), .frame_err(err_b));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       ext;
    } ev_t;

    ev_t        evq[$];
    ev_t        cur_ev;
    logic [7:0] m_key_a = 8'h00, m_key_b = 8'h00;
    logic       m_ext_a = 1'b0, m_ext_b = 1'b0;
    logic       m_brk = 1'b0, m_epd = 1'b0;
    logic       settled = 1'b0;
    int         fall_cyc = 0;
    logic [7:0] pool[10] = '{8'hE0, 8'hF0, 8'h1B, 8'h2D, 8'h4D, 8'h76, 8'h43, 8'h42, 8'h3B, 8'h4B};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model of the decode rules applied to one correctly received byte.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_epd = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            if (b == m_key_a && m_epd == m_ext_a) begin
                m_key_a = 8'h00;
                m_ext_a = 1'b0;
            end
            m_brk = 1'b0;
            m_epd = 1'b0;
        end else begin
            evq.push_back('{1'b0, b, m_epd});
            m_key_a = b;
            m_ext_a = m_epd;
            m_key_b = b;
            m_ext_b = m_epd;
            m_epd   = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_key_a = 8'h00; m_key_b = 8'h00;
        m_ext_a = 1'b0;  m_ext_b = 1'b0;
        m_brk   = 1'b0;  m_epd   = 1'b0;
        evq.delete();
    endtask

    // One PS/2 bit: data set while clock is high, then a full low phase.
    task automatic bit_tx(input logic d);
        @(negedge CLK);
        ps2_data = d;
        repeat (HALF) @(negedge CLK);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge CLK);
        ps2_clk = 1'b1;
    endtask

    task automatic settle_and_drain();
        repeat (HALF) @(negedge CLK);
        settled = 1'b1;
        check("events_drained", 32'(evq.size()), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        settled = 1'b0;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        if (bad_par || bad_stop) evq.push_back('{1'b1, 8'h00, 1'b0});
        else model_byte(b);
        for (int i = 0; i < 11; i++) bit_tx(bits[i]);
        settle_and_drain();
    endtask

    task automatic bad_start();
        settled = 1'b0;
        evq.push_back('{1'b1, 8'h00, 1'b0});
        bit_tx(1'b1);
        settle_and_drain();
    endtask

    task automatic partial(input int n, input logic expect_timeout);
        settled = 1'b0;
        if (expect_timeout) evq.push_back('{1'b1, 8'h00, 1'b0});
        bit_tx(1'b0);
        for (int i = 1; i < n; i++) bit_tx(1'($urandom_range(0, 1)));
        if (expect_timeout) begin
            repeat (TO + 2 * HALF) @(negedge CLK);
            settle_and_drain();
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #3 RESETN = 1'b0;
        #1;
        check("rst_keycode_a", 32'(kc_a), 32'h00);
        check("rst_keycode_b", 32'(kc_b), 32'h00);
        check("rst_strobe", 32'({stb_a, stb_b}), 32'd0);
        check("rst_ext", 32'({ext_a, ext_b}), 32'd0);
        check("rst_err", 32'({err_a, err_b}), 32'd0);
        model_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge CLK);
        RESETN  = 1'b1;
        settled = 1'b1;
    endtask

    // Compare process: every pulse must match the next predicted event; levels must match when settled.
    always @(negedge CLK) begin
        if (RESETN) begin
            check("strobe_err_exclusive_a", 32'(stb_a & err_a), 32'd0);
            check("strobe_err_exclusive_b", 32'(stb_b & err_b), 32'd0);
            if (stb_a || err_a || stb_b || err_b) begin
                if (evq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse actual=stb%0b%0b/err%0b%0b expected=none at cycle %0d",
                             stb_a, stb_b, err_a, err_b, cyc);
                end else begin
                    cur_ev = evq.pop_front();
                    check("pulse_kind_a", 32'({stb_a, err_a}), cur_ev.is_err ? 32'd1 : 32'd2);
                    check("pulse_kind_b", 32'({stb_b, err_b}), cur_ev.is_err ? 32'd1 : 32'd2);
                    if (!cur_ev.is_err) begin
                        check("strobe_code_a", 32'(kc_a), 32'(cur_ev.code));
                        check("strobe_code_b", 32'(kc_b), 32'(cur_ev.code));
                        check("strobe_ext_a", 32'(ext_a), 32'(cur_ev.ext));
                        check("strobe_ext_b", 32'(ext_b), 32'(cur_ev.ext));
                        check("strobe_latency", 32'(cyc - fall_cyc), 32'(LATENCY));
                    end
                end
            end
            if (settled) begin
                check("level_keycode_a", 32'(kc_a), 32'(m_key_a));
                check("level_keycode_b", 32'(kc_b), 32'(m_key_b));
                check("level_ext_a", 32'(ext_a), 32'(m_ext_a));
                check("level_ext_b", 32'(ext_b), 32'(m_ext_b));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=running expected=finished at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         r;
        do_reset();

        send_frame(8'h42, 1'b0, 1'b0);
        check("pin_42", 32'(kc_a), 32'h42);
        check("pin_42_ext", 32'(ext_a), 32'd0);

        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h42, 1'b0, 1'b0);
        check("pin_break_clear", 32'(kc_a), 32'h00);
        check("pin_break_hold", 32'(kc_b), 32'h42);

        send_frame(8'h42, 1'b0, 1'b0);
        send_frame(8'h43, 1'b1, 1'b0);
        check("pin_bad_parity_keep", 32'(kc_a), 32'h42);
        send_frame(8'h1B, 1'b0, 1'b0);
        check("pin_1b", 32'(kc_a), 32'h1B);

        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("pin_75", 32'(kc_a), 32'h75);
        check("pin_75_ext", 32'(ext_a), 32'd1);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h43, 1'b0, 1'b0);
        check("pin_nomatch_break", 32'(kc_a), 32'h75);

        bad_start();
        send_frame(8'h3B, 1'b0, 1'b1);

        partial(5, 1'b1);
        send_frame(8'h76, 1'b0, 1'b0);
        check("pin_76", 32'(kc_a), 32'h76);

        // Short glitch on the clock line must be absorbed by the filter.
        @(negedge CLK);
        ps2_clk = 1'b0;
        repeat (3) @(negedge CLK);
        ps2_clk = 1'b1;
        repeat (4 * FL) @(negedge CLK);
        check("glitch_no_event", 32'(evq.size()), 32'd0);
        check("glitch_keycode", 32'(kc_a), 32'h76);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 19);
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 9)];
            if (r == 0) send_frame(b, 1'b1, 1'b0);
            else if (r == 1) send_frame(b, 1'b0, 1'b1);
            else if (r == 2) bad_start();
            else send_frame(b, 1'b0, 1'b0);
        end

        partial(4, 1'b0);
        do_reset();
        send_frame(8'h2D, 1'b0, 1'b0);
        check("pin_2d_after_reset", 32'(kc_a), 32'h2D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
